inert_spi_resp: RTL and testbench
=================================

Name: inert_spi_resp

Overview:
- Synthesizable SPI responder that models the inertial sensor at the far end of the core's SS_n/SCLK/MOSI/MISO/INT link.
- Used in emulation and FPGA bring-up in place of the real sensor.
- Holds a small register file and latches pitch samples supplied by a stimulus source.
- Raises INT on each new sample and clears it once the master has read the sample's high byte.

Parameters:
- WHO_AM_I_VAL, 8'h6A, read-only identity value at address 0x0F.
- SYNC_STAGES, 2, flop stages on the SS_n, SCLK and MOSI synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; all logic is on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- SS_n  input  1  SPI slave select, active low, from the master.
- SCLK  input  1  SPI clock from the master; mode 0 (CPOL=0, CPHA=0).
- MOSI  input  1  master-out data, MSB first.
- MISO  output  1  slave-out data; driven 0 whenever no read data phase is active (never tri-stated).
- INT  output  1  data-ready interrupt to the master.
- ptch_in  input  16  new pitch sample from the stimulus source.
- ptch_vld  input  1  one-cycle strobe qualifying ptch_in.

Behaviour:
- Reset values:
  - MISO=0, INT=0.
  - INT_CFG (0x0D)=0x00, CTRL1 (0x10)=0x00.
  - Pitch sample=0x0000, PITCHH shadow=0x00.
  - Bit count=0, FSM=IDLE.
- Synchronization and timing:
  - SS_n, SCLK and MOSI pass through the SYNC_STAGES flop synchronizers.
  - SCLK rise and fall edges are detected in the clk domain.
  - Required SCLK high and low times are each ≥4 clk cycles; faster SCLK is unsupported.
- Frame format (16 bits, MSB first):
  - Bit 15: R/W, 1 = read.
  - Bits 14:8: address.
  - Bits 7:0: write data (don't-care for reads).
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE→CMD on synchronized SS_n fall; bit count cleared.
  - CMD: MOSI sampled on each SCLK rise into the 16-bit rx shift register.
  - CMD→DATA on the 8th rise. The address is decoded in the same cycle. For a read, the tx byte is loaded from the register file and MISO = tx[7].
  - DATA: MISO shifts to the next bit on each SCLK fall; MOSI is still sampled on each rise.
  - Any state→DONE on synchronized SS_n rise; DONE→IDLE after one cycle.
- In DONE:
  - If the bit count is exactly 16 and the frame is a write, the write is committed.
  - If the bit count is exactly 16 and the frame is a read of 0x23, INT is cleared.
  - Any other bit count: frame discarded, no side effects.
- SS_n rise mid-frame in any state aborts to DONE with the count ≠16, so nothing is committed. MISO returns to 0 on the cycle after SS_n rise is detected.
- Register map:
  - 0x0D INT_CFG (R/W); bit1 = int_en.
  - 0x0F WHO_AM_I (RO).
  - 0x10 CTRL1 (R/W).
  - 0x22 PITCHL (RO).
  - 0x23 PITCHH (RO).
  - Unmapped reads return 0x00. Writes to RO or unmapped addresses are ignored.
- Sample capture:
  - On ptch_vld with int_en=1, ptch_in is latched and INT=1 the following cycle.
  - On ptch_vld with int_en=0, the strobe is ignored.
  - ptch_vld while INT=1 overwrites the sample; INT stays 1.
- Coherency:
  - When a PITCHL read loads its tx byte, sample[15:8] is copied to the PITCHH shadow.
  - PITCHH reads return the shadow, so a new sample arriving between the two reads does not tear the pair.
- Simultaneous events:
  - ptch_vld in the same cycle as an INT clear: set wins, INT stays 1.
  - Clearing int_en by write does not drop an INT that is already asserted.
- rst asserted mid-frame returns everything to reset values immediately. The frame in flight is lost.

Test Plan:
- Read WHO_AM_I: frame 0x8F00 after reset → MISO bits 15:8 = 0, bits 7:0 = 0x6A; INT stays 0.
- INT handshake: write 0x0D02 → INT_CFG=0x02. Pulse ptch_vld with ptch_in=0x1234 → INT=1 one cycle later. Read 0xA2 → 0x34, INT stays 1. Read 0xA3 → 0x12, INT=0 after SS_n rise.
- Coherency: read PITCHL after sample 0x1234 → 0x34. Then pulse ptch_vld with 0xABCD before the PITCHH read → PITCHH returns 0x12 and INT stays 1. A following PITCHL read returns 0xCD.
- Aborted frame: write 0x10A5 with SS_n raised after 12 bits → CTRL1 stays 0x00; a subsequent full read of 0x90 returns 0x00.
- Interrupt disabled: int_en=0, pulse ptch_vld with 0x5555 → INT stays 0; PITCHL read returns the prior value.
- Set-vs-clear race: ptch_vld lands in the DONE cycle of a 0xA3 read → INT remains 1.
- Reset mid-frame: assert rst during a read data phase → MISO=0, INT=0, INT_CFG=0x00 immediately.

Source files
------------

// File: rtl/inert_spi_resp.sv
// rtl/inert_spi_resp.sv - SPI mode-0 responder emulating the inertial sensor link
// Register file, pitch sample latch with coherent high-byte shadow, and data-ready INT.
module inert_spi_resp #(
   parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_in,
   input  logic        ptch_vld
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   localparam logic [6:0] A_INT_CFG = 7'h0D;
   localparam logic [6:0] A_WHO     = 7'h0F;
   localparam logic [6:0] A_CTRL1   = 7'h10;
   localparam logic [6:0] A_PITCHL  = 7'h22;
   localparam logic [6:0] A_PITCHH  = 7'h23;

   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic                   ss_prev, sclk_prev;
   logic                   ss_s, sclk_s, mosi_s;
   logic                   ss_rise, ss_fall, sclk_rise, sclk_fall;

   state_t      state;
   logic [4:0]  bit_cnt;
   logic [15:0] rx;
   logic [15:0] rx_next;
   logic [6:0]  tx;
   logic        rd;
   logic        miso_q;
   logic        irq;
   logic [7:0]  int_cfg;
   logic [7:0]  ctrl1;
   logic [15:0] sample;
   logic [7:0]  shadow;
   logic [7:0]  rd_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         ss_prev   <= ss_s;
         sclk_prev <= sclk_s;
      end
   end

   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign ss_rise   = ss_s & ~ss_prev;
   assign ss_fall   = ~ss_s & ss_prev;
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign rx_next   = {rx[14:0], mosi_s};

   // Address is decoded from the shift value that will exist after the 8th rise.
   always_comb begin
      rd_byte = 8'h00;
      case (rx_next[6:0])
         A_INT_CFG: rd_byte = int_cfg;
         A_WHO:     rd_byte = WHO_AM_I_VAL;
         A_CTRL1:   rd_byte = ctrl1;
         A_PITCHL:  rd_byte = sample[7:0];
         A_PITCHH:  rd_byte = shadow;
         default:   rd_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= 5'd0;
         rx      <= 16'h0000;
         tx      <= 7'h00;
         rd      <= 1'b0;
         miso_q  <= 1'b0;
         irq     <= 1'b0;
         int_cfg <= 8'h00;
         ctrl1   <= 8'h00;
         sample  <= 16'h0000;
         shadow  <= 8'h00;
      end else begin
         if (ss_rise && state != DONE) begin
            state  <= DONE;
            miso_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_fall) begin
                     state   <= CMD;
                     bit_cnt <= 5'd0;
                     rd      <= 1'b0;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     rx      <= rx_next;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        state <= DATA;
                        rd    <= rx_next[7];
                        if (rx_next[7]) begin
                           miso_q <= rd_byte[7];
                           tx     <= rd_byte[6:0];
                           if (rx_next[6:0] == A_PITCHL)
                              shadow <= sample[15:8];
                        end
                     end
                  end
               end
               DATA: begin
                  if (sclk_rise) begin
                     rx <= rx_next;
                     if (bit_cnt != 5'd31)
                        bit_cnt <= bit_cnt + 5'd1;
                  end else if (sclk_fall && rd && bit_cnt > 5'd8) begin
                     // The fall right after the command byte keeps the data MSB on MISO.
                     miso_q <= tx[6];
                     tx     <= {tx[5:0], 1'b0};
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  miso_q <= 1'b0;
                  rd     <= 1'b0;
                  if (bit_cnt == 5'd16) begin
                     if (!rx[15]) begin
                        case (rx[14:8])
                           A_INT_CFG: int_cfg <= rx[7:0];
                           A_CTRL1:   ctrl1   <= rx[7:0];
                           default:   ;
                        endcase
                     end else if (rx[14:8] == A_PITCHH) begin
                        irq <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // Placed after the clear so a same-cycle new sample keeps INT asserted.
         if (ptch_vld && int_cfg[1]) begin
            sample <= ptch_in;
            irq    <= 1'b1;
         end
      end
   end

   assign MISO = miso_q;
   assign INT  = irq;

endmodule

// File: tb/tb_inert_spi_resp.sv
// tb/tb_inert_spi_resp.sv - directed bench for inert_spi_resp
module tb_inert_spi_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        INT;
   logic [15:0] ptch_in;
   logic        ptch_vld;

   int n_checks = 0;
   int n_fail   = 0;

   inert_spi_resp #(.WHO_AM_I_VAL(8'h6A), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .INT(INT), .ptch_in(ptch_in), .ptch_vld(ptch_vld)
   );

   always #5 clk = ~clk;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [15:0] cmd, input int nbits, output logic [15:0] got);
      got = 16'h0000;
      @(negedge clk);
      SS_n = 1'b0;
      wait_clks(6);
      for (int i = 0; i < nbits; i++) begin
         MOSI = cmd[15-i];
         wait_clks(5);
         SCLK = 1'b1;
         got  = {got[14:0], MISO};
         wait_clks(5);
         SCLK = 1'b0;
      end
      wait_clks(5);
   endtask

   task automatic spi_end();
      SS_n = 1'b1;
      MOSI = 1'b0;
      wait_clks(6);
   endtask

   task automatic spi_frame(input logic [15:0] cmd, output logic [15:0] got);
      spi_bits(cmd, 16, got);
      spi_end();
   endtask

   task automatic pulse(input logic [15:0] d);
      @(negedge clk);
      ptch_in  = d;
      ptch_vld = 1'b1;
      @(negedge clk);
      ptch_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      ptch_in = 16'h0000; ptch_vld = 1'b0;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(2);
      n_checks++;
      if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b exp 0", MISO); end
      n_checks++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b exp 0", INT); end
   endtask

   task automatic test_who_am_i();
      logic [15:0] got;
      spi_frame(16'h8F00, got);
      n_checks++;
      if (got !== 16'h006A) begin n_fail++; $display("FAIL who_am_i got %h exp 006a", got); end
      n_checks++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL who_int got %b exp 0", INT); end
      n_checks++;
      if (MISO !== 1'b0) begin n_fail++; $display("FAIL who_miso_idle got %b exp 0", MISO); end
   endtask

   task automatic test_int_handshake();
      logic [15:0] got;
      spi_frame(16'h0D02, got);
      spi_frame(16'h8D00, got);
      n_checks++;
      if (got !== 16'h0002) begin n_fail++; $display("FAIL int_cfg_rd got %h exp 0002", got); end
      @(negedge clk);
      ptch_in = 16'h1234; ptch_vld = 1'b1;
      n_checks++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL int_pre got %b exp 0", INT); end
      @(negedge clk);
      ptch_vld = 1'b0;
      n_checks++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL int_set got %b exp 1", INT); end
      spi_frame(16'hA200, got);
      n_checks++;
      if (got !== 16'h0034) begin n_fail++; $display("FAIL hs_pitchl got %h exp 0034", got); end
      n_checks++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL hs_int_after_l got %b exp 1", INT); end
      spi_frame(16'hA300, got);
      n_checks++;
      if (got !== 16'h0012) begin n_fail++; $display("FAIL hs_pitchh got %h exp 0012", got); end
      n_checks++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL hs_int_clr got %b exp 0", INT); end
   endtask

   task automatic test_coherency();
      logic [15:0] got;
      pulse(16'h1234);
      spi_frame(16'hA200, got);
      n_checks++;
      if (got !== 16'h0034) begin n_fail++; $display("FAIL coh_l1 got %h exp 0034", got); end
      pulse(16'hABCD);
      n_checks++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL coh_int got %b exp 1", INT); end
      spi_frame(16'hA300, got);
      n_checks++;
      if (got !== 16'h0012) begin n_fail++; $display("FAIL coh_h1 got %h exp 0012", got); end
      spi_frame(16'hA200, got);
      n_checks++;
      if (got !== 16'h00CD) begin n_fail++; $display("FAIL coh_l2 got %h exp 00cd", got); end
      spi_frame(16'hA300, got);
      n_checks++;
      if (got !== 16'h00AB) begin n_fail++; $display("FAIL coh_h2 got %h exp 00ab", got); end
   endtask

   task automatic test_abort();
      logic [15:0] got;
      spi_bits(16'h10A5, 12, got);
      spi_end();
      n_checks++;
      if (MISO !== 1'b0) begin n_fail++; $display("FAIL abort_miso got %b exp 0", MISO); end
      spi_frame(16'h9000, got);
      n_checks++;
      if (got !== 16'h0000) begin n_fail++; $display("FAIL abort_ctrl1 got %h exp 0000", got); end
      spi_frame(16'h10A5, got);
      spi_frame(16'h9000, got);
      n_checks++;
      if (got !== 16'h00A5) begin n_fail++; $display("FAIL full_ctrl1 got %h exp 00a5", got); end
      spi_frame(16'h0F55, got);
      spi_frame(16'h8F00, got);
      n_checks++;
      if (got !== 16'h006A) begin n_fail++; $display("FAIL ro_write got %h exp 006a", got); end
   endtask

   task automatic test_int_disabled();
      logic [15:0] got;
      pulse(16'h7788);
      spi_frame(16'h0D00, got);
      n_checks++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL dis_keep_int got %b exp 1", INT); end
      pulse(16'h5555);
      spi_frame(16'hA200, got);
      n_checks++;
      if (got !== 16'h0088) begin n_fail++; $display("FAIL dis_pitchl got %h exp 0088", got); end
      spi_frame(16'hA300, got);
      n_checks++;
      if (got !== 16'h0077) begin n_fail++; $display("FAIL dis_pitchh got %h exp 0077", got); end
      n_checks++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL dis_int_clr got %b exp 0", INT); end
      pulse(16'h5555);
      n_checks++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL dis_no_set got %b exp 0", INT); end
      spi_frame(16'hA200, got);
      n_checks++;
      if (got !== 16'h0088) begin n_fail++; $display("FAIL dis_pitchl2 got %h exp 0088", got); end
   endtask

   task automatic test_race();
      logic [15:0] got;
      spi_frame(16'h0D02, got);
      pulse(16'h2222);
      spi_bits(16'hA300, 16, got);
      n_checks++;
      if (got !== 16'h0077) begin n_fail++; $display("FAIL race_pitchh got %h exp 0077", got); end
      SS_n = 1'b1;
      MOSI = 1'b0;
      wait_clks(3);
      ptch_in = 16'h3344; ptch_vld = 1'b1;
      @(negedge clk);
      ptch_vld = 1'b0;
      n_checks++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL race_int got %b exp 1", INT); end
      wait_clks(4);
      n_checks++;
      if (INT !== 1'b1) begin n_fail++; $display("FAIL race_int_hold got %b exp 1", INT); end
      spi_frame(16'hA200, got);
      n_checks++;
      if (got !== 16'h0044) begin n_fail++; $display("FAIL race_pitchl got %h exp 0044", got); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] got;
      pulse(16'h00F0);
      spi_bits(16'hA200, 9, got);
      n_checks++;
      if (MISO !== 1'b1) begin n_fail++; $display("FAIL mid_miso_pre got %b exp 1", MISO); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (MISO !== 1'b0) begin n_fail++; $display("FAIL mid_rst_miso got %b exp 0", MISO); end
      n_checks++;
      if (INT !== 1'b0) begin n_fail++; $display("FAIL mid_rst_int got %b exp 0", INT); end
      SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(3);
      spi_frame(16'h8D00, got);
      n_checks++;
      if (got !== 16'h0000) begin n_fail++; $display("FAIL mid_int_cfg got %h exp 0000", got); end
      spi_frame(16'h9000, got);
      n_checks++;
      if (got !== 16'h0000) begin n_fail++; $display("FAIL mid_ctrl1 got %h exp 0000", got); end
      spi_frame(16'hA200, got);
      n_checks++;
      if (got !== 16'h0000) begin n_fail++; $display("FAIL mid_pitchl got %h exp 0000", got); end
   endtask

   initial begin
      test_reset();
      test_who_am_i();
      test_int_handshake();
      test_coherency();
      test_abort();
      test_int_disabled();
      test_race();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
